// File: rtl/seg_scan_mux_if.sv
// Display-side signal bundle for seg_scan_mux: glyph/score inputs from game
// logic and the multiplexed on-board / PMOD pin outputs.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] glyph_bus;
  logic                    hex_mode;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [6:0]              score;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic [6:0]              sc_seg;
  logic                    sc_sel;
  logic                    scan_tick;

  modport master (
    output glyph_bus, hex_mode, blink_mask, blank_mask, dp_mask, score,
    input  an, seg, sc_seg, sc_sel, scan_tick
  );

  modport slave (
    input  glyph_bus, hex_mode, blink_mask, blank_mask, dp_mask, score,
    output an, seg, sc_seg, sc_sel, scan_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-digit blink/blank/dp control
// plus a two-digit decimal PMOD score display fed from a binary score.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned CLK_DIV     = 1000,
  parameter int unsigned BLINK_TICKS = 256
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [6:0] SC_DASH = 7'b1000000;

  typedef enum logic {
    SEL_TENS = 1'b0,
    SEL_ONES = 1'b1
  } sc_sel_e;

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick;
  logic [IW-1:0]         idx_q, idx_d, idx_nx;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, an_nx;
  logic [7:0]            seg_q, seg_d, seg_nx;
  sc_sel_e               sel_q, sel_d;
  logic [6:0]            sc_lat_q, sc_lat_d;
  logic [6:0]            sc_seg_q, sc_seg_d;
  logic                  scan_tick_q;

  logic [4:0]            glyph_sel;
  logic                  blink_sel, blank_sel, dp_sel;
  logic [6:0]            glyph_seg;
  logic [6:0]            split_in, tens, ones;

  // Letter glyphs, active-low gfedcba (dp bit handled separately).
  function automatic logic [6:0] letter_seg(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h08;
      5'd1:    s = 7'h03;
      5'd2:    s = 7'h27;
      5'd3:    s = 7'h21;
      5'd4:    s = 7'h04;
      5'd5:    s = 7'h0E;
      5'd6:    s = 7'h10;
      5'd7:    s = 7'h09;
      5'd8:    s = 7'h79;
      5'd9:    s = 7'h61;
      5'd11:   s = 7'h07;
      5'd13:   s = 7'h48;
      5'd14:   s = 7'h40;
      5'd15:   s = 7'h0C;
      5'd16:   s = 7'h18;
      5'd17:   s = 7'h0F;
      5'd18:   s = 7'h12;
      5'd19:   s = 7'h4E;
      5'd20:   s = 7'h51;
      5'd24:   s = 7'h11;
      5'd27:   s = 7'h7F;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // PMOD digits are active-high gfedcba.
  function automatic logic [6:0] dig_pat(input logic [6:0] v);
    logic [6:0] s;
    case (v)
      7'd0:    s = 7'h3F;
      7'd1:    s = 7'h06;
      7'd2:    s = 7'h5B;
      7'd3:    s = 7'h4F;
      7'd4:    s = 7'h66;
      7'd5:    s = 7'h6D;
      7'd6:    s = 7'h7D;
      7'd7:    s = 7'h07;
      7'd8:    s = 7'h7F;
      7'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Repeated subtraction; nine steps cover 0..99, larger values are dashed anyway.
  function automatic logic [13:0] split_dec(input logic [6:0] v);
    logic [6:0] r;
    logic [6:0] t;
    r = v;
    t = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 7'd1;
      end
    end
    return {t, r};
  endfunction

  assign tick   = (presc_q == PW'(CLK_DIV - 1));
  assign idx_nx = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

  // Everything the next slot displays is derived from the index it moves to.
  always_comb begin
    glyph_sel = '0;
    blink_sel = 1'b0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    an_nx     = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (idx_nx == IW'(d)) begin
        glyph_sel = bus.glyph_bus[5*d +: 5];
        blink_sel = bus.blink_mask[d];
        blank_sel = bus.blank_mask[d];
        dp_sel    = bus.dp_mask[d];
        an_nx[d]  = 1'b0;
      end
    end
  end

  always_comb begin
    glyph_seg = bus.hex_mode ? hex_seg(glyph_sel[3:0]) : letter_seg(glyph_sel);
    if (blank_sel || (blink_sel && blink_ph_q)) begin
      seg_nx = 8'hFF;
    end else begin
      seg_nx = {~dp_sel, glyph_seg};
    end
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (tick) begin
      idx_d = idx_nx;
      an_d  = an_nx;
      seg_d = seg_nx;
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // The tens slot converts the live score while latching it; the ones slot
  // reuses the latch, so both halves of a pair come from one sample.
  always_comb begin
    split_in = (sel_q == SEL_ONES) ? bus.score : sc_lat_q;
    {tens, ones} = split_dec(split_in);
  end

  always_comb begin
    sel_d    = sel_q;
    sc_lat_d = sc_lat_q;
    sc_seg_d = sc_seg_q;
    if (tick) begin
      if (sel_q == SEL_ONES) begin
        sel_d    = SEL_TENS;
        sc_lat_d = bus.score;
        if (split_in > 7'd99)     sc_seg_d = SC_DASH;
        else if (tens == 7'd0)    sc_seg_d = '0;
        else                      sc_seg_d = dig_pat(tens);
      end else begin
        sel_d = SEL_ONES;
        if (split_in > 7'd99)     sc_seg_d = SC_DASH;
        else                      sc_seg_d = dig_pat(ones);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      an_q        <= '1;
      seg_q       <= 8'hFF;
      sel_q       <= SEL_TENS;
      sc_lat_q    <= '0;
      sc_seg_q    <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      sc_lat_q    <= sc_lat_d;
      sc_seg_q    <= sc_seg_d;
      scan_tick_q <= tick;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.sc_seg    = sc_seg_q;
  assign bus.sc_sel    = (sel_q == SEL_ONES);
  assign bus.scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with CLK_DIV=4, BLINK_TICKS=2, NUM_DIGITS=4;
// every scan slot is a directed vector with hand-derived pin values.
module tb_seg_scan_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .BLINK_TICKS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [19:0] glyph;
    logic        hex;
    logic [3:0]  blink;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [6:0]  score;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [6:0]  sc;
    logic        sel;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic [6:0] sc;
    logic       sel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ticks_seen = 0;

  function automatic logic [19:0] g4(input int unsigned c3, c2, c1, c0);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic add(input logic [19:0] g, input logic hx, input logic [3:0] bl,
                     input logic [3:0] bk, input logic [3:0] dpm, input logic [6:0] scr,
                     input logic [3:0] e_an, input logic [7:0] e_seg,
                     input logic [6:0] e_sc, input logic e_sel);
    vec_t v;
    v.glyph = g;    v.hex = hx;     v.blink = bl;   v.blank = bk;
    v.dp = dpm;     v.score = scr;  v.an = e_an;    v.seg = e_seg;
    v.sc = e_sc;    v.sel = e_sel;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    bus.glyph_bus  = v.glyph;
    bus.hex_mode   = v.hex;
    bus.blink_mask = v.blink;
    bus.blank_mask = v.blank;
    bus.dp_mask    = v.dp;
    bus.score      = v.score;
    e.an = v.an; e.seg = v.seg; e.sc = v.sc; e.sel = v.sel;
    sb.push_back(e);
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.scan_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got no scan_tick expected one within 20 clks");
    end
  endtask

  // Monitor: every falling edge, pins must match the slot last announced by scan_tick.
  initial begin : monitor
    exp_t cur;
    int   cyc;
    cur = '{an: 4'hF, seg: 8'hFF, sc: 7'h00, sel: 1'b0};
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur = '{an: 4'hF, seg: 8'hFF, sc: 7'h00, sel: 1'b0};
        cyc = 0;
      end else begin
        cyc++;
        if (bus.scan_tick === 1'b1) begin
          ticks_seen++;
          check("tick_interval", 8'(cyc), 8'd4);
          cyc = 0;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tick: got scan_tick expected none queued");
          end else begin
            cur = sb.pop_front();
          end
        end
      end
      check("an", {4'h0, bus.an}, {4'h0, cur.an});
      check("seg", bus.seg, cur.seg);
      check("sc_seg", {1'b0, bus.sc_seg}, {1'b0, cur.sc});
      check("sc_sel", {7'h0, bus.sc_sel}, {7'h0, cur.sel});
    end
  end

  initial begin : stimulus
    logic [19:0] idle, lt, l10, hx;
    idle = g4(27, 27, 27, 27);
    lt   = g4(3, 2, 1, 0);
    l10  = g4(3, 2, 10, 0);
    hx   = {5'h19, 5'h0B, 5'h05, 5'h1C};

    //   glyph hex blink    blank    dp       score  an       seg    sc     sel
    add(idle, 0, 4'b0000, 4'b0000, 4'b0000, 7'd0,   4'b1101, 8'hFF, 7'h3F, 1);
    add(idle, 0, 4'b0000, 4'b0000, 4'b0000, 7'd0,   4'b1011, 8'hFF, 7'h00, 0);
    add(idle, 0, 4'b0000, 4'b0000, 4'b0000, 7'd0,   4'b0111, 8'hFF, 7'h3F, 1);
    add(idle, 0, 4'b0000, 4'b0000, 4'b0000, 7'd0,   4'b1110, 8'hFF, 7'h00, 0);
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b1101, 8'h83, 7'h3F, 1);
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b1011, 8'hA7, 7'h66, 0);
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b0111, 8'hA1, 7'h5B, 1);
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b1110, 8'h88, 7'h66, 0);
    add(l10,  0, 4'b0000, 4'b0000, 4'b0000, 7'd57,  4'b1101, 8'hBF, 7'h5B, 1);
    add(l10,  0, 4'b0000, 4'b0000, 4'b0000, 7'd57,  4'b1011, 8'hA7, 7'h6D, 0);
    add(l10,  0, 4'b0000, 4'b0000, 4'b0000, 7'd57,  4'b0111, 8'hA1, 7'h07, 1);
    add(hx,   1, 4'b0000, 4'b0000, 4'b0001, 7'd7,   4'b1110, 8'h46, 7'h00, 0);
    add(hx,   1, 4'b0000, 4'b0000, 4'b0001, 7'd7,   4'b1101, 8'h92, 7'h07, 1);
    add(hx,   1, 4'b0000, 4'b0000, 4'b0001, 7'd100, 4'b1011, 8'h83, 7'h40, 0);
    add(hx,   1, 4'b0000, 4'b0000, 4'b0001, 7'd100, 4'b0111, 8'h90, 7'h40, 1);
    add(lt,   0, 4'b1111, 4'b0000, 4'b0000, 7'd99,  4'b1110, 8'hFF, 7'h6F, 0);
    add(lt,   0, 4'b1111, 4'b0000, 4'b0000, 7'd99,  4'b1101, 8'h83, 7'h6F, 1);
    add(lt,   0, 4'b1111, 4'b0000, 4'b0000, 7'd99,  4'b1011, 8'hA7, 7'h6F, 0);
    add(lt,   0, 4'b1111, 4'b0000, 4'b0000, 7'd99,  4'b0111, 8'hFF, 7'h6F, 1);
    add(lt,   0, 4'b0001, 4'b0010, 4'b1111, 7'd10,  4'b1110, 8'hFF, 7'h06, 0);
    add(lt,   0, 4'b0001, 4'b0010, 4'b1111, 7'd10,  4'b1101, 8'hFF, 7'h3F, 1);
    add(lt,   0, 4'b0001, 4'b0010, 4'b1111, 7'd10,  4'b1011, 8'h27, 7'h06, 0);
    add(lt,   0, 4'b0001, 4'b0010, 4'b1111, 7'd10,  4'b0111, 8'h21, 7'h3F, 1);
    // after the mid-slot reset: counters, phase and latched score restart
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b1101, 8'h83, 7'h3F, 1);
    add(lt,   0, 4'b0000, 4'b0000, 4'b0000, 7'd42,  4'b1011, 8'hA7, 7'h66, 0);

    rst_n          = 1'b0;
    bus.glyph_bus  = idle;
    bus.hex_mode   = 1'b0;
    bus.blink_mask = '0;
    bus.blank_mask = '0;
    bus.dp_mask    = '0;
    bus.score      = '0;
    repeat (3) @(negedge clk);
    check("rst_scan_tick", {7'h0, bus.scan_tick}, 8'h00);
    #2 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 23) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_an", {4'h0, bus.an}, 8'h0F);
        check("async_seg", bus.seg, 8'hFF);
        check("async_sc_seg", {1'b0, bus.sc_seg}, 8'h00);
        check("async_sc_sel", {7'h0, bus.sc_sel}, 8'h00);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
      apply(vecs[i]);
      wait_tick();
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'd0);
    check("tick_count", 8'(ticks_seen), 8'd25);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised successor to the hangman display driver.
- Time-multiplexes NUM_DIGITS on-board 7-segment digits (letter glyphs or hex), with per-digit blink, blank and decimal-point control.
- Also drives a 2-digit PMOD score display from a binary score, converting it to decimal internally.
- Sits between game logic (glyph and score registers) and the board pins (an, seg, PMOD JA/JB).

Parameters:
- NUM_DIGITS, 4, number of on-board multiplexed digits (2..8).
- CLK_DIV, 1000, clk cycles per scan tick (>=2).
- BLINK_TICKS, 256, scan ticks per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- glyph_bus  in  5*NUM_DIGITS  glyph code per digit; digit d uses bits [5d+4:5d]; digit 0 is rightmost.
- hex_mode  in  1  0 = letter table, 1 = hex table (low 4 bits of the glyph).
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- blank_mask  in  NUM_DIGITS  1 = digit forced dark.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit.
- score  in  7  score value, 0..127.
- an  out  NUM_DIGITS  anodes, active-low, one-cold.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- sc_seg  out  7  PMOD segments {g,f,e,d,c,b,a}, active-high.
- sc_sel  out  1  PMOD cathode select: 0 = tens (left), 1 = ones (right).
- scan_tick  out  1  one-cycle pulse per scan step.

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, digit index=0, blink counter=0, blink phase=0.
  - an=all 1s, seg=8'hFF, sc_seg=0, sc_sel=0, scan_tick=0, latched score=0.
- Prescaler: counts 0..CLK_DIV-1 and wraps.
  - Asserts an internal tick in the cycle it holds CLK_DIV-1.
  - scan_tick is the registered tick, so it rises 1 clk later; exactly 1 clk wide.
- Digit index: advances on each tick, wrapping NUM_DIGITS-1 -> 0.
  - an/seg update in the same registered cycle as scan_tick and reflect the new index d.
  - Inputs are sampled on the tick cycle and are stable for the whole slot.
  - an[d]=0, all other an bits =1.
- seg derivation for digit d:
  - If blank_mask[d], or (blink_mask[d] and blink phase=1): seg=8'hFF; an[d] is still driven low.
  - Else seg[6:0] comes from the glyph table; seg[7] = ~dp_mask[d].
- Letter table (seg[6:0] shown as 8-bit with dp off):
  - 0 a=88, 1 b=83, 2 c=A7, 3 d=A1, 4 e=84, 5 f=8E, 6 g=90, 7 h=89, 8 i=F9, 9 j=E1.
  - 11 l=87, 13 n=C8, 14 o=C0, 15 p=8C, 16 q=98, 17 r=8F, 18 s=92, 19 t=CE, 20 u=D1, 24 y=91.
  - 27 = blank FF. All other codes = dash BF.
- Hex table:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8.
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - Glyph bit 4 is ignored in hex mode.
- Blink: counter counts ticks 0..BLINK_TICKS-1. At wrap the blink phase toggles and the counter returns to 0. Blink masks affect only the displayed output, never the counters.
- Score channel:
  - sc_sel toggles on every tick.
  - On a tick that sets sc_sel=0, score is latched and split into tens/ones, with the result available in that same registered output cycle. Both digits of a pair therefore come from one sample (no tearing).
  - Latched value > 99: both digits show dash (sc_seg=7'b1000000).
  - Tens = 0: tens digit blank (sc_seg=0); ones is always shown.
  - Digit patterns (active-high gfedcba): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F.
- Input changes between ticks are invisible until the next tick.
- Reset mid-slot returns all outputs to reset values immediately. After release the first scan_tick occurs CLK_DIV cycles later and selects digit 1 (index 0 -> 1).

Test Plan (CLK_DIV=4, BLINK_TICKS=2, NUM_DIGITS=4):
- Reset release, idle: scan_tick every 4 clks; an sequence 1101, 1011, 0111, 1110, repeating; seg=FF until the first tick with glyph 27.
- Letter mode, glyph_bus = {d,c,b,a} = codes 3,2,1,0 -> seg A1/A7/83/88 with an 0111/1011/1101/1110; code 10 -> BF.
- hex_mode=1, digit0 code 5'h1C, dp_mask=0001 -> seg=46 when an=1110.
- blink_mask=0001 -> digit 0 shows its glyph for 2 ticks, then FF for 2 ticks, alternating; blank_mask=0010 -> digit 1 always FF.
- score=42 -> sc_sel 0: sc_seg 66; sc_sel 1: 5B. score=7 -> tens 00, ones 07. score=100 -> 40/40.
- score changes 42 -> 57 while sc_sel=1 -> ones still shows 5B; next pair shows 6D then 07.
- rst_n pulsed low mid-slot -> an=1111, seg=FF, sc_seg=0 asynchronously; recovers per the reset rule.
